multicycle_alu: RTL

Parametrised, clocked successor of the processor's 8-bit ALU. Same operation set and SELECT encoding, plus a start/done handshake. Operands and results are WIDTH bits wide. Results, ZERO and a new CARRY flag are registered. Multiply is an iterative shift-add unit that stalls the datapath through BUSY; all other operations complete in one cycle.

---
 rtl/multicycle_alu_if.sv | 35 +++
 rtl/multicycle_alu.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/multicycle_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu_if
// Purpose  : Request/result bundle between a requester and multicycle_alu.
//            Signal suffixes are written from the ALU's point of view
//            (_i = into the ALU, _o = out of the ALU).
// Signals  : start_i, data1_i, data2_i, select_i, shift_dir_i  (request)
//            result_o, zero_o, carry_o, busy_o, done_o          (response)
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_alu_if #(
  parameter int WIDTH = 8
) ();
  logic             start_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [2:0]       select_i;
  logic             shift_dir_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             carry_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, data1_i, data2_i, select_i, shift_dir_i,
    input  result_o, zero_o, carry_o, busy_o, done_o
  );

  modport slave (
    input  start_i, data1_i, data2_i, select_i, shift_dir_i,
    output result_o, zero_o, carry_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Purpose  : Clocked WIDTH-bit ALU with start/done handshake. Forward, add,
//            and, or, shifts and rotate finish in one cycle; unsigned
//            multiply runs as a WIDTH-step shift-add sequence under busy.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            bus        multicycle_alu_if.slave (request in, result out)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_alu_if.slave  bus
);

  localparam int              CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   C_LAST  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_WIDTH = WIDTH'(WIDTH);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               carry_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  // Single-cycle datapath
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   rot_amt;
  logic [2*WIDTH-1:0] rot_dbl;
  logic [WIDTH-1:0]   res_d;
  logic               cry_d;

  // Shift-add step
  logic [2*WIDTH-1:0] mul_term;
  logic [2*WIDTH-1:0] acc_d;

  always_comb begin
    sum     = {1'b0, bus.data1_i} + {1'b0, bus.data2_i};
    rot_amt = bus.data2_i % C_WIDTH;
    // Rotating right is a right shift of the operand concatenated with itself.
    rot_dbl = {bus.data1_i, bus.data1_i} >> rot_amt;
    res_d   = '0;
    cry_d   = 1'b0;
    case (bus.select_i)
      OP_FWD: res_d = bus.data2_i;
      OP_ADD: begin
        res_d = sum[WIDTH-1:0];
        cry_d = sum[WIDTH];
      end
      OP_AND: res_d = bus.data1_i & bus.data2_i;
      OP_OR:  res_d = bus.data1_i | bus.data2_i;
      // Native shifts already yield 0 / sign fill for amounts >= WIDTH.
      OP_SHL: res_d = bus.shift_dir_i ? (bus.data1_i >> bus.data2_i)
                                      : (bus.data1_i << bus.data2_i);
      OP_SRA: res_d = $signed(bus.data1_i) >>> bus.data2_i;
      OP_ROR: res_d = rot_dbl[WIDTH-1:0];
      default: res_d = '0;
    endcase
  end

  always_comb begin
    mul_term = '0;
    if (mplier_q[cnt_q]) begin
      mul_term = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    end
    acc_d = acc_q + mul_term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            if (bus.select_i == OP_MUL) begin
              mcand_q  <= bus.data1_i;
              mplier_q <= bus.data2_i;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= ST_MUL;
            end else begin
              result_q <= res_d;
              zero_q   <= (res_d == '0);
              carry_q  <= cry_d;
              done_q   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          // start_i is not looked at here: requests during a multiply are dropped.
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            result_q <= acc_d[WIDTH-1:0];
            zero_q   <= (acc_d[WIDTH-1:0] == '0);
            carry_q  <= |acc_d[2*WIDTH-1:WIDTH];
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;
  assign bus.carry_o  = carry_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;

endmodule
`default_nettype wire
